// File: rtl/mmio_bus_controller.sv
// mmio_bus_controller
// Memory-mapped bus controller between the core data port and N_SLV slaves.
// It decodes base/mask address ranges, with the lowest slave index taking
// priority. It inserts per-slave wait states before a one-cycle slave strobe.
// It returns registered read data, or an error response for unmapped accesses.
//
// Optional feature macro: BUS_ALIGN_CHECK_EN
//   When defined, a request whose bus_addr[1:0] is not 0 is answered as
//   unmapped. When undefined, the low address bits are ignored.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   bus_req/bus_wren  core request and direction (1 = write)
//   bus_addr          byte address
//   bus_wrdata        write data
//   bus_ready         one-cycle completion pulse
//   bus_rddata        read data, valid with bus_ready
//   bus_err           error flag, valid with bus_ready
//   slv_addr          latched word offset inside the selected slave
//   slv_wrdata        latched write data
//   slv_wren/rden     one-hot, one-cycle slave strobes
//   slv_rddata        packed slave read data, slave 0 in the LSBs
module mmio_bus_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_SLV  = 4,
  parameter int unsigned WAIT_W = 4,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE =
    {32'h10000020, 32'h10000000, 32'h10010000, 32'h00400000},
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK =
    {32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFF00000},
  parameter logic [N_SLV*WAIT_W-1:0] SLV_WAIT =
    {4'd3, 4'd1, 4'd0, 4'd0}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bus_req,
  input  logic                    bus_wren,
  input  logic [ADDR_W-1:0]       bus_addr,
  input  logic [DATA_W-1:0]       bus_wrdata,
  output logic                    bus_ready,
  output logic [DATA_W-1:0]       bus_rddata,
  output logic                    bus_err,
  output logic [ADDR_W-1:0]       slv_addr,
  output logic [DATA_W-1:0]       slv_wrdata,
  output logic [N_SLV-1:0]        slv_wren,
  output logic [N_SLV-1:0]        slv_rden,
  input  logic [N_SLV*DATA_W-1:0] slv_rddata
);

  localparam int unsigned IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic [IDX_W-1:0]  sel_q;
  logic              wren_q;
  logic              err_q;

  logic              hit_c;
  logic              map_ok_c;
  logic [IDX_W-1:0]  hit_idx_c;
  logic [ADDR_W-1:0] offs_c;
  logic [WAIT_W-1:0] wait_c;
  logic [DATA_W-1:0] rd_arr [N_SLV];

  // Unpack slave read data for indexed selection
  for (genvar g = 0; g < int'(N_SLV); g++) begin : g_rd
    assign rd_arr[g] = slv_rddata[g*DATA_W +: DATA_W];
  end

  // Address decode; scanning downwards lets the lowest hitting index win
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    offs_c    = '0;
    wait_c    = '0;
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if ((bus_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
        offs_c    = (bus_addr & ~SLV_MASK[i*ADDR_W +: ADDR_W]) >> 2;
        wait_c    = SLV_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
  end

`ifdef BUS_ALIGN_CHECK_EN
  assign map_ok_c = hit_c & (bus_addr[1:0] == 2'b00);
`else
  assign map_ok_c = hit_c;
`endif

  // Controller FSM with registered strobes and response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_q      <= '0;
      wren_q     <= 1'b0;
      err_q      <= 1'b0;
      bus_ready  <= 1'b0;
      bus_err    <= 1'b0;
      bus_rddata <= '0;
      slv_addr   <= '0;
      slv_wrdata <= '0;
      slv_wren   <= '0;
      slv_rden   <= '0;
    end else begin
      slv_wren  <= '0;
      slv_rden  <= '0;
      bus_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus_req) begin
            if (map_ok_c) begin
              state      <= ACCESS;
              cnt        <= wait_c;
              sel_q      <= hit_idx_c;
              wren_q     <= bus_wren;
              err_q      <= 1'b0;
              slv_addr   <= offs_c;
              slv_wrdata <= bus_wrdata;
            end else begin
              // Unmapped: skip the slave entirely and answer with an error
              state      <= RESP;
              err_q      <= 1'b1;
              bus_rddata <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
          end else begin
            if (wren_q) begin
              slv_wren <= N_SLV'(1) << sel_q;
            end else begin
              slv_rden   <= N_SLV'(1) << sel_q;
              bus_rddata <= rd_arr[sel_q];
            end
            state <= RESP;
          end
        end
        RESP: begin
          // bus_req is ignored here; the pulse lands in the following IDLE cycle
          bus_ready <= 1'b1;
          bus_err   <= err_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Self-checking bench for mmio_bus_controller.
// A cycle-indexed expectation table is filled when each request is issued.
// A negedge compare process checks every cycle against the table.
module tb_mmio_bus_controller;

  localparam int MAXC = 2048;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         bus_req = 1'b0;
  logic         bus_wren = 1'b0;
  logic [31:0]  bus_addr = '0;
  logic [31:0]  bus_wrdata = '0;
  logic         bus_ready;
  logic [31:0]  bus_rddata;
  logic         bus_err;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wrdata;
  logic [3:0]   slv_wren;
  logic [3:0]   slv_rden;
  logic [127:0] slv_rddata;

  logic [31:0] sdata [4];
  assign slv_rddata = {sdata[3], sdata[2], sdata[1], sdata[0]};

  mmio_bus_controller dut (
    .clk        (clk),
    .rst        (rst),
    .bus_req    (bus_req),
    .bus_wren   (bus_wren),
    .bus_addr   (bus_addr),
    .bus_wrdata (bus_wrdata),
    .bus_ready  (bus_ready),
    .bus_rddata (bus_rddata),
    .bus_err    (bus_err),
    .slv_addr   (slv_addr),
    .slv_wrdata (slv_wrdata),
    .slv_wren   (slv_wren),
    .slv_rden   (slv_rden),
    .slv_rddata (slv_rddata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Address map in slave-index order
  localparam logic [31:0] MBASE [4] = '{32'h00400000, 32'h10010000, 32'h10000000, 32'h10000020};
  localparam logic [31:0] MMASK [4] = '{32'hFFF00000, 32'hFFFF0000, 32'hFFFFFFF0, 32'hFFFFFFF0};
  localparam int          MWAIT [4] = '{0, 0, 1, 3};

  // Expectations per cycle (index = posedge count after which outputs apply)
  logic [3:0]  e_wren  [MAXC];
  logic [3:0]  e_rden  [MAXC];
  logic        e_ready [MAXC];
  logic        e_err   [MAXC];
  logic [31:0] e_rd    [MAXC];
  logic        e_av    [MAXC];
  logic [31:0] e_sa    [MAXC];
  logic [31:0] e_sw    [MAXC];
  logic [31:0] m_rd;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_on  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      e_wren[c] = '0; e_rden[c] = '0; e_ready[c] = 1'b0; e_err[c] = 1'b0;
      e_rd[c] = '0; e_av[c] = 1'b0; e_sa[c] = '0; e_sw[c] = '0;
    end
  endtask

  // Model: request sampled at edge s produces strobe at s+W+1, ready at s+W+2
  task automatic model_issue(input logic [31:0] a, input bit w, input logic [31:0] wd, input int s);
    int idx;
    bit ok;
    int wt;
    idx = -1;
    for (int i = 0; i < 4; i++)
      if (idx < 0 && ((a & MMASK[i]) == (MBASE[i] & MMASK[i]))) idx = i;
    ok = (idx >= 0);
`ifdef BUS_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) ok = 1'b0;
`endif
    if (s + 20 >= MAXC) return;
    if (!ok) begin
      m_rd = '0;
      e_ready[s+1] = 1'b1;
      e_err[s+1]   = 1'b1;
      e_rd[s+1]    = '0;
    end else begin
      wt = MWAIT[idx];
      if (w) e_wren[s+wt+1] = 4'(1 << idx);
      else begin
        e_rden[s+wt+1] = 4'(1 << idx);
        m_rd = sdata[idx];
      end
      e_ready[s+wt+2] = 1'b1;
      e_err[s+wt+2]   = 1'b0;
      e_rd[s+wt+2]    = m_rd;
      for (int c = s; c <= s + wt + 1; c++) begin
        e_av[c] = 1'b1;
        e_sa[c] = (a & ~MMASK[idx]) >> 2;
        e_sw[c] = wd;
      end
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      check("slv_wren", 32'(slv_wren), 32'(e_wren[cyc]));
      check("slv_rden", 32'(slv_rden), 32'(e_rden[cyc]));
      check("bus_ready", 32'(bus_ready), 32'(e_ready[cyc]));
      if (e_ready[cyc]) begin
        check("bus_err", 32'(bus_err), 32'(e_err[cyc]));
        check("bus_rddata", bus_rddata, e_rd[cyc]);
      end
      if (e_av[cyc]) begin
        check("slv_addr", slv_addr, e_sa[cyc]);
        check("slv_wrdata", slv_wrdata, e_sw[cyc]);
      end
    end
  end

  // Issue one request from posedge+1; returns latencies relative to sampling edge
  task automatic txn(input logic [31:0] a, input bit w, input logic [31:0] wd, input bit toggle,
                     output int s, output int rdy_lat, output int stb_lat,
                     output logic [31:0] rd, output logic er,
                     output logic [31:0] sa, output logic [31:0] sw);
    bus_req = 1'b1; bus_wren = w; bus_addr = a; bus_wrdata = wd;
    s = cyc + 1;
    model_issue(a, w, wd, s);
    rdy_lat = -1; stb_lat = -1; rd = '0; er = 1'b0; sa = '0; sw = '0;
    for (int b = 0; b < 40; b++) begin
      @(posedge clk); #1;
      if (toggle && cyc >= s) begin
        bus_addr = $urandom; bus_wrdata = $urandom; bus_wren = ~bus_wren;
      end
      if (slv_wren != '0 || slv_rden != '0) begin
        stb_lat = cyc - s; sa = slv_addr; sw = slv_wrdata;
      end
      if (bus_ready) begin
        rdy_lat = cyc - s; rd = bus_rddata; er = bus_err;
        bus_req = 1'b0;
        break;
      end
    end
    if (rdy_lat < 0) begin
      check("ready_timeout", 32'hFFFFFFFF, 32'h0);
      bus_req = 1'b0;
    end
  endtask

  int s1, s2, rl, sl;
  logic [31:0] rd, sa, sw;
  logic er;

  initial begin
    clear_from(0);
    m_rd = '0;
    sdata[0] = 32'h0BADF00D;
    sdata[1] = 32'hDEADBEEF;
    sdata[2] = 32'h000000C3;
    sdata[3] = 32'h5A5A0055;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check("rst_ready", 32'(bus_ready), 32'h0);
    check("rst_err", 32'(bus_err), 32'h0);
    check("rst_rddata", bus_rddata, 32'h0);
    check("rst_slv_addr", slv_addr, 32'h0);
    check("rst_strobes", 32'({slv_wren, slv_rden}), 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // RAM read, W=0
    txn(32'h10010008, 1'b0, 32'h0, 1'b0, s1, rl, sl, rd, er, sa, sw);
    check("ram_rdy_lat", 32'(rl), 32'd2);
    check("ram_stb_lat", 32'(sl), 32'd1);
    check("ram_slv_addr", sa, 32'd2);
    check("ram_rddata", rd, 32'hDEADBEEF);
    check("ram_err", 32'(er), 32'h0);

    // GPIO write, W=1: rddata keeps the last read value
    @(posedge clk); #1;
    txn(32'h10000000, 1'b1, 32'h000000A5, 1'b0, s1, rl, sl, rd, er, sa, sw);
    check("gpio_stb_lat", 32'(sl), 32'd2);
    check("gpio_rdy_lat", 32'(rl), 32'd3);
    check("gpio_wrdata", sw, 32'h000000A5);
    check("gpio_rddata_hold", rd, 32'hDEADBEEF);

    // UART read, W=3, inputs toggling during the wait
    @(posedge clk); #1;
    txn(32'h10000024, 1'b0, 32'h0, 1'b1, s1, rl, sl, rd, er, sa, sw);
    check("uart_stb_lat", 32'(sl), 32'd4);
    check("uart_rdy_lat", 32'(rl), 32'd5);
    check("uart_slv_addr", sa, 32'd1);
    check("uart_rddata", rd, 32'h5A5A0055);

    // Unmapped
    @(posedge clk); #1;
    txn(32'h20000000, 1'b0, 32'h0, 1'b0, s1, rl, sl, rd, er, sa, sw);
    check("unmap_rdy_lat", 32'(rl), 32'd1);
    check("unmap_stb", 32'(sl), 32'hFFFFFFFF);
    check("unmap_err", 32'(er), 32'h1);
    check("unmap_rddata", rd, 32'h0);

    // ROM read, then back-to-back GPIO writes and a RAM read
    @(posedge clk); #1;
    txn(32'h00400010, 1'b0, 32'h0, 1'b0, s1, rl, sl, rd, er, sa, sw);
    check("rom_slv_addr", sa, 32'd4);
    check("rom_rddata", rd, 32'h0BADF00D);
    txn(32'h10000004, 1'b1, 32'h12345678, 1'b0, s1, rl, sl, rd, er, sa, sw);
    txn(32'h10000008, 1'b1, 32'h9ABCDEF0, 1'b0, s2, rl, sl, rd, er, sa, sw);
    check("b2b_spacing", 32'(s2 - s1), 32'd4);
    check("b2b_slv_addr", sa, 32'd2);
    txn(32'h1001FFFC, 1'b0, 32'h0, 1'b0, s1, rl, sl, rd, er, sa, sw);
    check("ram_top_slv_addr", sa, 32'h3FFF);

    // Misaligned RAM read
    @(posedge clk); #1;
    txn(32'h10010002, 1'b0, 32'h0, 1'b0, s1, rl, sl, rd, er, sa, sw);
`ifdef BUS_ALIGN_CHECK_EN
    check("misalign_err", 32'(er), 32'h1);
    check("misalign_stb", 32'(sl), 32'hFFFFFFFF);
`else
    check("misalign_err", 32'(er), 32'h0);
    check("misalign_slv_addr", sa, 32'h0);
    check("misalign_rddata", rd, 32'hDEADBEEF);
`endif

    // Reset during a UART wait: transaction dropped, outputs cleared at once
    @(posedge clk); #1;
    bus_req = 1'b1; bus_wren = 1'b0; bus_addr = 32'h10000020;
    s1 = cyc + 1;
    model_issue(32'h10000020, 1'b0, 32'h0, s1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_from(cyc);
    m_rd = '0;
    bus_req = 1'b0;
    #1;
    check("midrst_ready", 32'(bus_ready), 32'h0);
    check("midrst_rddata", bus_rddata, 32'h0);
    check("midrst_slv_addr", slv_addr, 32'h0);
    check("midrst_strobes", 32'({slv_wren, slv_rden}), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    txn(32'h10000020, 1'b0, 32'h0, 1'b0, s1, rl, sl, rd, er, sa, sw);
    check("post_rst_rdy_lat", 32'(rl), 32'd5);
    check("post_rst_rddata", rd, 32'h5A5A0055);

    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
